// File: rtl/program_sequencer_if.sv
// ============================================================================
// Module   : program_sequencer_if
// Purpose  : Load/control/issue bundle between a host and program_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface program_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              stop;
    logic [31:0]       inst;
    logic              inst_stb;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic              load_err;

    modport master (
        output load_en, load_addr, load_data, prog_len, start, stop,
        input  inst, inst_stb, pc, busy, done, load_err
    );

    modport slave (
        input  load_en, load_addr, load_data, prog_len, start, stop,
        output inst, inst_stb, pc, busy, done, load_err
    );
endinterface

`default_nettype wire

// File: rtl/program_sequencer.sv
// ============================================================================
// Module   : program_sequencer
// Purpose  : Holds a program image and issues each word on inst for
//            INST_CYCLES clocks; inst is forced to NOP whenever not issuing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_sequencer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int INST_CYCLES = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    program_sequencer_if.slave   bus
);
    localparam int CNT_W = (INST_CYCLES > 2) ? $clog2(INST_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q,   len_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              stop_q,  stop_d;
    logic [31:0]       inst_q,  inst_d;
    logic              stb_q,   stb_d;
    logic              lerr_q,  lerr_d;
    logic [31:0]       mem_q [DEPTH];

    logic [ADDR_W:0]   w_len_sat;
    logic              w_last_cycle;
    logic              w_last_word;

    // Program memory has no reset; writes are refused while a run is live.
    always_ff @(posedge clk) begin
        if (bus.load_en && (state_q != S_ISSUE)) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    assign w_len_sat    = (bus.prog_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH)
                                                              : bus.prog_len;
    assign w_last_cycle = (cnt_q == CNT_W'(INST_CYCLES - 1));
    assign w_last_word  = ({1'b0, pc_q} == (len_q - 1'b1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        inst_d  = 32'h0;
        stb_d   = 1'b0;
        lerr_d  = bus.load_en && (state_q == S_ISSUE);

        case (state_q)
            S_IDLE: begin
                pc_d   = '0;
                cnt_d  = '0;
                stop_d = 1'b0;
                if (bus.start) begin
                    if (w_len_sat != '0) begin
                        state_d = S_ISSUE;
                        len_d   = w_len_sat;
                        inst_d  = mem_q[ADDR_W'(0)];
                        stb_d   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                inst_d = inst_q;
                stop_d = stop_q | bus.stop;
                cnt_d  = cnt_q + 1'b1;
                // A stop seen on the final hold cycle still ends the run here.
                if (w_last_cycle) begin
                    cnt_d = '0;
                    if (w_last_word || stop_q || bus.stop) begin
                        state_d = S_DONE;
                        inst_d  = 32'h0;
                        stop_d  = 1'b0;
                    end else begin
                        pc_d   = pc_q + 1'b1;
                        inst_d = mem_q[pc_q + 1'b1];
                        stb_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            inst_q  <= 32'h0;
            stb_q   <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            inst_q  <= inst_d;
            stb_q   <= stb_d;
            lerr_q  <= lerr_d;
        end
    end

    assign bus.inst     = inst_q;
    assign bus.inst_stb = stb_q;
    assign bus.pc       = pc_q;
    assign bus.busy     = (state_q == S_ISSUE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.load_err = lerr_q;

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// ============================================================================
// Module   : tb_program_sequencer
// Purpose  : Self-checking bench for program_sequencer against a per-cycle
//            expectation queue built from the issue rules.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_sequencer;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int IC     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    program_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    program_sequencer #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .INST_CYCLES(IC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic        stb;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] mem_m [DEPTH];
    int          checks = 0;
    int          errors = 0;
    bit          last_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Every cycle out of reset: pop the expected outputs, or expect idle NOP.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (q.size() > 0) e = q.pop_front();
            else              e = '{inst: 32'h0, stb: 1'b0, pc: 4'h0, busy: 1'b0, done: 1'b0};
            chk("inst",     bus.inst,          e.inst);
            chk("inst_stb", {31'b0, bus.inst_stb}, {31'b0, e.stb});
            chk("busy",     {31'b0, bus.busy},     {31'b0, e.busy});
            chk("done",     {31'b0, bus.done},     {31'b0, e.done});
            if (e.busy) chk("pc", {28'b0, bus.pc}, {28'b0, e.pc});
            chk("load_err", {31'b0, bus.load_err}, {31'b0, bus.load_en && last_busy});
            last_busy = e.busy;
        end else begin
            last_busy = 1'b0;
        end
    end

    task automatic load(input int a, input logic [31:0] d);
        @(negedge clk);
        bus.load_en   = 1'b1;
        bus.load_addr = a[3:0];
        bus.load_data = d;
        mem_m[a]      = d;
        @(negedge clk);
        bus.load_en   = 1'b0;
    endtask

    task automatic run(input int len, input int stop_at, input int load_at,
                       input int rst_at, input bit pin,
                       output int busy_cnt, output logic [3:0] last_pc);
        int eff, nw, total;
        eff = (len > DEPTH) ? DEPTH : len;
        nw  = eff;
        if (stop_at > 0 && ((stop_at - 1) / IC + 1) < nw) nw = (stop_at - 1) / IC + 1;
        total = nw * IC + 1;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.prog_len = len[4:0];
        for (int w = 0; w < nw; w++)
            for (int c = 0; c < IC; c++)
                q.push_back('{inst: mem_m[w], stb: (c == 0), pc: w[3:0], busy: 1'b1, done: 1'b0});
        q.push_back('{inst: 32'h0, stb: 1'b0, pc: 4'h0, busy: 1'b0, done: 1'b1});
        busy_cnt = 0;
        last_pc  = 4'h0;
        for (int cyc = 1; cyc <= total + 1; cyc++) begin
            @(negedge clk);
            if (bus.busy) begin
                busy_cnt++;
                last_pc = bus.pc;
            end
            if (pin) begin
                if (cyc == 1)  chk("pin_w0",    bus.inst, 32'h00001037);
                if (cyc == 1)  chk("pin_stb0",  {31'b0, bus.inst_stb}, 32'd1);
                if (cyc == 4)  chk("pin_w0end", bus.inst, 32'h00001037);
                if (cyc == 5)  chk("pin_w1",    bus.inst, 32'h00000012);
                if (cyc == 9)  chk("pin_w2",    bus.inst, 32'h00000029);
                if (cyc == 13) chk("pin_done",  {31'b0, bus.done}, 32'd1);
                if (cyc == 14) chk("pin_nop",   bus.inst, 32'h0);
            end
            if (load_at > 0 && cyc == load_at + 1)
                chk("load_err_pulse", {31'b0, bus.load_err}, 32'd1);
            // Extra start pulses land in ISSUE and DONE and must be ignored.
            bus.start     = (cyc == total) || (eff > 0 && cyc == 2);
            bus.stop      = (cyc == stop_at);
            bus.load_en   = (cyc == load_at);
            bus.load_addr = 4'h0;
            bus.load_data = 32'hDEADBEEF;
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                q.delete();
                #1;
                chk("rst_inst", bus.inst, 32'h0);
                chk("rst_busy", {31'b0, bus.busy}, 32'd0);
                chk("rst_pc",   {28'b0, bus.pc},   32'd0);
                bus.start   = 1'b0;
                bus.stop    = 1'b0;
                bus.load_en = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
        end
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.load_en = 1'b0;
    endtask

    int          bc;
    logic [3:0]  lp;

    initial begin
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.prog_len  = '0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_inst",     bus.inst,                32'h0);
        chk("reset_stb",      {31'b0, bus.inst_stb},   32'd0);
        chk("reset_pc",       {28'b0, bus.pc},         32'd0);
        chk("reset_busy",     {31'b0, bus.busy},       32'd0);
        chk("reset_done",     {31'b0, bus.done},       32'd0);
        chk("reset_load_err", {31'b0, bus.load_err},   32'd0);
        rst_n = 1'b1;

        load(0, 32'h00001037);
        load(1, 32'h00000012);
        load(2, 32'h00000029);
        for (int i = 3; i < DEPTH; i++)
            load(i, (i == 5) ? 32'h00000F80 : (32'h10000013 + i * 32'h111));

        run(3, 0, 0, 0, 1'b1, bc, lp);
        chk("run3_busy_cycles", bc, 12);

        run(0, 0, 0, 0, 1'b0, bc, lp);
        chk("len0_busy_cycles", bc, 0);

        run(4, 7, 0, 0, 1'b0, bc, lp);
        chk("stop_busy_cycles", bc, 8);
        chk("stop_last_pc", {28'b0, lp}, 32'd1);

        run(4, 0, 3, 0, 1'b0, bc, lp);
        run(1, 0, 0, 0, 1'b0, bc, lp);

        run(5, 0, 0, 6, 1'b0, bc, lp);
        run(2, 0, 0, 0, 1'b0, bc, lp);
        chk("post_rst_busy_cycles", bc, 8);

        run(16, 0, 0, 0, 1'b0, bc, lp);
        chk("full_busy_cycles", bc, 64);
        chk("full_last_pc", {28'b0, lp}, 32'd15);

        run(20, 0, 0, 0, 1'b0, bc, lp);
        chk("sat_busy_cycles", bc, 64);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
